fp_cmp_pipe: RTL

Parametrised, pipelined floating-point comparator and min/max unit for bfloat16 and other narrow IEEE-style formats.
It accepts a stream of operand pairs over a valid/ready handshake and produces a 2-bit relation code plus a selected min/max result.
Comparison is done by direct sign/magnitude evaluation, not by subtraction, so the result is exact for every encoding, including zeros, subnormals, infinities and NaN.
It sits between the bfloat MAC datapath and the sort/activation (ReLU, max-pool) logic.

---
 rtl/fp_cmp_pipe.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fp_cmp_pipe.sv
// Pipelined sign/magnitude floating-point comparator with IEEE minNum/maxNum selection.
// Stage 1 holds operands, stage min(2,LAT) holds the relation, the last stage holds the selected result.
module fp_cmp_pipe #(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 7,
    parameter int  LAT   = 2,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   cmp,
    output logic [W-1:0] res,
    output logic         nan_flag
);

    localparam int MW = 2 * W + 5;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic f_is_nan(input logic [W-1:0] x);
        return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    function automatic logic f_is_zero(input logic [W-1:0] x);
        return ~|x[W-2:0];
    endfunction

    function automatic logic [1:0] f_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [1:0] rel;
        rel = 2'b00;
        if (f_is_nan(x) || f_is_nan(y)) begin
            rel = 2'b11;
        end else if ((f_is_zero(x) && f_is_zero(y)) || (x == y)) begin
            rel = 2'b00;
        end else if (x[W-1] != y[W-1]) begin
            rel = x[W-1] ? 2'b10 : 2'b01;
        end else if (x[W-2:0] > y[W-2:0]) begin
            // Larger magnitude is greater when positive, lesser when negative
            rel = x[W-1] ? 2'b10 : 2'b01;
        end else begin
            rel = x[W-1] ? 2'b01 : 2'b10;
        end
        return rel;
    endfunction

    function automatic logic [W-1:0] f_sel(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [1:0] sel_op, input logic [1:0] rel);
        logic [W-1:0] r;
        r = x;
        if (sel_op == 2'b01 || sel_op == 2'b10) begin
            if (rel == 2'b11) begin
                if (f_is_nan(x) && f_is_nan(y)) begin
                    r = QNAN;
                end else if (f_is_nan(x)) begin
                    r = y;
                end
            end else if (rel == 2'b00) begin
                // Equal with differing signs only happens for +0/-0
                if (x[W-1] != y[W-1]) begin
                    r = ((sel_op == 2'b01) == x[W-1]) ? x : y;
                end
            end else if (sel_op == 2'b01) begin
                r = (rel == 2'b10) ? x : y;
            end else begin
                r = (rel == 2'b01) ? x : y;
            end
        end
        return r;
    endfunction

    logic         r_out_valid;
    logic [1:0]   r_cmp;
    logic [W-1:0] r_res;
    logic         r_nan;
    logic         w_adv;

    logic         w_pre_valid;
    logic [W-1:0] w_pre_a;
    logic [W-1:0] w_pre_b;
    logic [1:0]   w_pre_op;
    logic [MW-1:0] w_mid_bus;
    logic [MW-1:0] w_sel_bus;

    logic         w_sel_valid;
    logic [W-1:0] w_sel_a;
    logic [W-1:0] w_sel_b;
    logic [1:0]   w_sel_op;
    logic [1:0]   w_sel_cmp;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign cmp       = r_cmp;
    assign res       = r_res;
    assign nan_flag  = r_nan;

    generate
        if (LAT == 1) begin : g_no_s1
            assign w_pre_valid = in_valid;
            assign w_pre_a     = a;
            assign w_pre_b     = b;
            assign w_pre_op    = op;
        end else begin : g_s1
            logic         r_s1_valid;
            logic [W-1:0] r_s1_a;
            logic [W-1:0] r_s1_b;
            logic [1:0]   r_s1_op;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_valid <= 1'b0;
                    r_s1_a     <= '0;
                    r_s1_b     <= '0;
                    r_s1_op    <= '0;
                end else if (w_adv) begin
                    r_s1_valid <= in_valid;
                    r_s1_a     <= a;
                    r_s1_b     <= b;
                    r_s1_op    <= op;
                end
            end
            assign w_pre_valid = r_s1_valid;
            assign w_pre_a     = r_s1_a;
            assign w_pre_b     = r_s1_b;
            assign w_pre_op    = r_s1_op;
        end
    endgenerate

    assign w_mid_bus = {w_pre_valid, w_pre_a, w_pre_b, w_pre_op, f_cmp(w_pre_a, w_pre_b)};

    // Relation stage followed by pass-through stages when LAT > 2
    generate
        if (LAT >= 3) begin : g_mid
            for (genvar gi = 0; gi < LAT - 2; gi++) begin : g_stage
                logic [MW-1:0] r_stage;
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            r_stage <= '0;
                        end else if (w_adv) begin
                            r_stage <= w_mid_bus;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            r_stage <= '0;
                        end else if (w_adv) begin
                            r_stage <= g_stage[gi-1].r_stage;
                        end
                    end
                end
            end
            assign w_sel_bus = g_stage[LAT-3].r_stage;
        end else begin : g_no_mid
            assign w_sel_bus = w_mid_bus;
        end
    endgenerate

    assign {w_sel_valid, w_sel_a, w_sel_b, w_sel_op, w_sel_cmp} = w_sel_bus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_cmp       <= '0;
            r_res       <= '0;
            r_nan       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_sel_valid;
            r_cmp       <= w_sel_cmp;
            r_res       <= f_sel(w_sel_a, w_sel_b, w_sel_op, w_sel_cmp);
            r_nan       <= (w_sel_cmp == 2'b11);
        end
    end

endmodule
